// File: rtl/lcd_frame_ctrl_if.sv
// Application/LCD-pin bundle for lcd_frame_ctrl: message registers and handshake
// on one side, HD44780 8-bit bus on the other.
interface lcd_frame_ctrl_if #(
    parameter int COLS = 16,
    parameter int ROWS = 2
);
    logic [8*COLS*ROWS-1:0] msg;
    logic                   update;
    logic                   busy;
    logic                   frame_done;
    logic                   rs;
    logic                   rw;
    logic                   en;
    logic [7:0]             data;

    modport master (
        output msg, update,
        input  busy, frame_done, rs, rw, en, data
    );

    modport slave (
        input  msg, update,
        output busy, frame_done, rs, rw, en, data
    );
endinterface

// File: rtl/lcd_frame_ctrl.sv
// Parametrised HD44780 character-LCD frame controller (8-bit mode): power-up wait,
// init sequence, then snapshot-based frame refresh on request or continuously.
module lcd_frame_ctrl #(
    parameter int CLK_DIV       = 12000,
    parameter int EN_TICKS      = 10,
    parameter int POWERUP_TICKS = 20,
    parameter int COLS          = 16,
    parameter int ROWS          = 2,
    parameter int AUTO_REFRESH  = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    lcd_frame_ctrl_if.slave bus
);

    localparam int NCHAR   = COLS * ROWS;
    localparam int SNAP_IW = (8 * NCHAR > 1) ? $clog2(8 * NCHAR) : 1;
    localparam int TICK_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_MAX = (2 * EN_TICKS > POWERUP_TICKS) ? 2 * EN_TICKS : POWERUP_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  PU_LAST   = CNT_W'(POWERUP_TICKS - 1);
    localparam logic [CNT_W-1:0]  SLOT_LAST = CNT_W'(EN_TICKS - 1);
    localparam logic [CNT_W-1:0]  CLR_LAST  = CNT_W'(2 * EN_TICKS - 1);
    localparam logic [CNT_W-1:0]  EN_LAST   = CNT_W'(EN_TICKS - 2);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_INIT,
        ST_IDLE,
        ST_FRAME_START,
        ST_ADDR,
        ST_CHAR
    } state_t;

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = 8'h38;
            2'd1:    b = 8'h0C;
            2'd2:    b = 8'h01;
            2'd3:    b = 8'h06;
            default: b = 8'h38;
        endcase
        return b;
    endfunction

    function automatic logic [7:0] row_addr(input logic [ROW_W-1:0] r);
        logic [1:0] r2;
        logic [7:0] off;
        r2 = 2'(r);
        case (r2)
            2'd0:    off = 8'h00;
            2'd1:    off = 8'h40;
            2'd2:    off = 8'(COLS);
            2'd3:    off = 8'h40 + 8'(COLS);
            default: off = 8'h00;
        endcase
        return 8'h80 | off;
    endfunction

    // NUL characters are shown as spaces so every cell is overwritten.
    function automatic logic [7:0] char_at(input logic [8*NCHAR-1:0] s,
                                           input logic [ROW_W-1:0]   r,
                                           input logic [COL_W-1:0]   c);
        int                 idx;
        logic [SNAP_IW-1:0] base;
        logic [7:0]         b;
        idx  = NCHAR - 1 - (int'(r) * COLS + int'(c));
        base = SNAP_IW'(idx * 8);
        b    = s[base +: 8];
        return (b == 8'h00) ? 8'h20 : b;
    endfunction

    logic [TICK_W-1:0]      tick_cnt_r;
    logic                   tick_s;
    state_t                 state_r, state_nx;
    logic [CNT_W-1:0]       slot_cnt_r, slot_cnt_nx, slot_last_s;
    logic [1:0]             init_idx_r, init_idx_nx;
    logic [ROW_W-1:0]       row_r, row_nx;
    logic [COL_W-1:0]       col_r, col_nx;
    logic                   pending_r, pending_nx;
    logic [8*NCHAR-1:0]     snap_r;
    logic                   snap_load_s, pending_clr_s, go_again_s;
    logic                   rs_r, rs_nx;
    logic                   en_r, en_nx;
    logic [7:0]             data_r, data_nx;
    logic                   busy_r, busy_nx;
    logic                   frame_done_r, frame_done_nx;

    assign tick_s = (tick_cnt_r == TICK_LAST);

    // Free-running tick divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_r <= '0;
        end else if (tick_s) begin
            tick_cnt_r <= '0;
        end else begin
            tick_cnt_r <= tick_cnt_r + TICK_W'(1);
        end
    end

    // State, counters, snapshot and registered LCD/handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_POWERUP;
            slot_cnt_r   <= '0;
            init_idx_r   <= 2'd0;
            row_r        <= '0;
            col_r        <= '0;
            pending_r    <= 1'b0;
            snap_r       <= '0;
            rs_r         <= 1'b0;
            en_r         <= 1'b0;
            data_r       <= 8'h00;
            busy_r       <= 1'b1;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_nx;
            slot_cnt_r   <= slot_cnt_nx;
            init_idx_r   <= init_idx_nx;
            row_r        <= row_nx;
            col_r        <= col_nx;
            pending_r    <= pending_nx;
            snap_r       <= snap_load_s ? bus.msg : snap_r;
            rs_r         <= rs_nx;
            en_r         <= en_nx;
            data_r       <= data_nx;
            busy_r       <= busy_nx;
            frame_done_r <= frame_done_nx;
        end
    end

    // Next-state and slot sequencing; a new slot's rs/data load with en low.
    always_comb begin
        state_nx      = state_r;
        slot_cnt_nx   = slot_cnt_r;
        init_idx_nx   = init_idx_r;
        row_nx        = row_r;
        col_nx        = col_r;
        rs_nx         = rs_r;
        en_nx         = en_r;
        data_nx       = data_r;
        busy_nx       = busy_r;
        frame_done_nx = 1'b0;
        snap_load_s   = 1'b0;
        pending_clr_s = 1'b0;
        go_again_s    = pending_r || bus.update || (AUTO_REFRESH != 0);
        slot_last_s   = (state_r == ST_INIT && init_idx_r == 2'd2) ? CLR_LAST : SLOT_LAST;

        case (state_r)
            ST_POWERUP: begin
                busy_nx = 1'b1;
                en_nx   = 1'b0;
                if (tick_s && slot_cnt_r == PU_LAST) begin
                    state_nx    = ST_INIT;
                    slot_cnt_nx = '0;
                    init_idx_nx = 2'd0;
                    rs_nx       = 1'b0;
                    data_nx     = init_byte(2'd0);
                end else if (tick_s) begin
                    slot_cnt_nx = slot_cnt_r + CNT_W'(1);
                end else begin
                    slot_cnt_nx = slot_cnt_r;
                end
            end

            ST_IDLE: begin
                en_nx = 1'b0;
                if (tick_s && go_again_s) begin
                    state_nx = ST_FRAME_START;
                    busy_nx  = 1'b1;
                end else begin
                    busy_nx  = 1'b0;
                end
            end

            // Zero-length: one clk to take the snapshot, then the first ADDR slot.
            ST_FRAME_START: begin
                snap_load_s   = 1'b1;
                pending_clr_s = 1'b1;
                busy_nx       = 1'b1;
                row_nx        = '0;
                col_nx        = '0;
                slot_cnt_nx   = '0;
                state_nx      = ST_ADDR;
                rs_nx         = 1'b0;
                en_nx         = 1'b0;
                data_nx       = row_addr('0);
            end

            ST_INIT, ST_ADDR, ST_CHAR: begin
                if (tick_s && slot_cnt_r != slot_last_s) begin
                    slot_cnt_nx = slot_cnt_r + CNT_W'(1);
                    en_nx       = (slot_cnt_r < EN_LAST);
                end else if (tick_s) begin
                    slot_cnt_nx = '0;
                    en_nx       = 1'b0;
                    case (state_r)
                        ST_INIT: begin
                            if (init_idx_r == 2'd3) begin
                                state_nx = ST_IDLE;
                                busy_nx  = 1'b0;
                            end else begin
                                init_idx_nx = init_idx_r + 2'd1;
                                rs_nx       = 1'b0;
                                data_nx     = init_byte(init_idx_r + 2'd1);
                            end
                        end
                        ST_ADDR: begin
                            state_nx = ST_CHAR;
                            col_nx   = '0;
                            rs_nx    = 1'b1;
                            data_nx  = char_at(snap_r, row_r, '0);
                        end
                        ST_CHAR: begin
                            if (col_r != COL_LAST) begin
                                col_nx  = col_r + COL_W'(1);
                                data_nx = char_at(snap_r, row_r, col_r + COL_W'(1));
                            end else if (row_r != ROW_LAST) begin
                                row_nx   = row_r + ROW_W'(1);
                                state_nx = ST_ADDR;
                                rs_nx    = 1'b0;
                                data_nx  = row_addr(row_r + ROW_W'(1));
                            end else begin
                                frame_done_nx = 1'b1;
                                if (go_again_s) begin
                                    state_nx = ST_FRAME_START;
                                end else begin
                                    state_nx = ST_IDLE;
                                    busy_nx  = 1'b0;
                                end
                            end
                        end
                        default: begin
                            state_nx = ST_POWERUP;
                        end
                    endcase
                end else begin
                    slot_cnt_nx = slot_cnt_r;
                end
            end

            default: begin
                state_nx    = ST_POWERUP;
                slot_cnt_nx = '0;
                busy_nx     = 1'b1;
                en_nx       = 1'b0;
            end
        endcase
    end

    // Any request is remembered; a request in the snapshot clk still wins.
    always_comb begin
        if (bus.update) begin
            pending_nx = 1'b1;
        end else if (pending_clr_s) begin
            pending_nx = 1'b0;
        end else begin
            pending_nx = pending_r;
        end
    end

    assign bus.rs         = rs_r;
    assign bus.rw         = 1'b0;
    assign bus.en         = en_r;
    assign bus.data       = data_r;
    assign bus.busy       = busy_r;
    assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_lcd_frame_ctrl.sv
// Directed bench for lcd_frame_ctrl: a 4x2 instance driven through a vector table
// and corner sequences, plus a 20x4 auto-refresh instance run alongside.
module tb_lcd_frame_ctrl;

    typedef struct packed {
        logic [63:0] msg;
        logic [89:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a_n, rst_b_n;
    int   n_vec, n_err;

    lcd_frame_ctrl_if #(.COLS(4),  .ROWS(2)) if_a ();
    lcd_frame_ctrl_if #(.COLS(20), .ROWS(4)) if_b ();

    lcd_frame_ctrl #(
        .CLK_DIV(4), .EN_TICKS(4), .POWERUP_TICKS(5),
        .COLS(4), .ROWS(2), .AUTO_REFRESH(0)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_a_n),
        .bus   (if_a)
    );

    lcd_frame_ctrl #(
        .CLK_DIV(2), .EN_TICKS(4), .POWERUP_TICKS(2),
        .COLS(20), .ROWS(4), .AUTO_REFRESH(1)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_b_n),
        .bus   (if_b)
    );

    always #5 clk = ~clk;

    // Capture {rs,data} at every en falling edge and count frame_done pulses.
    logic [8:0] q_a[$];
    logic [8:0] q_b[$];
    logic       pe_a_m = 1'b0;
    logic       pe_b_m = 1'b0;
    int         fd_a_cnt = 0;
    int         fd_b_cnt = 0;
    int         fd_b_qs[2];
    logic       b_drop = 1'b0;

    always @(negedge clk) begin
        if (pe_a_m && !if_a.en) q_a.push_back({if_a.rs, if_a.data});
        pe_a_m <= if_a.en;
        if (if_a.frame_done) fd_a_cnt <= fd_a_cnt + 1;
    end

    always @(negedge clk) begin
        if (pe_b_m && !if_b.en) q_b.push_back({if_b.rs, if_b.data});
        pe_b_m <= if_b.en;
        if (if_b.frame_done && fd_b_cnt < 2) fd_b_qs[fd_b_cnt] <= q_b.size();
        if (if_b.frame_done) fd_b_cnt <= fd_b_cnt + 1;
        if (fd_b_cnt == 1 && !if_b.busy) b_drop <= 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_a();
        @(posedge clk);
        #1 if_a.update = 1'b1;
        @(posedge clk);
        #1 if_a.update = 1'b0;
    endtask

    task automatic check_frame(input string name, input int base, input logic [89:0] expv);
        logic [89:0] e;
        e = expv;
        for (int k = 0; k < 10; k++) begin
            check($sformatf("%s[%0d]", name, k), 32'(q_a[base + k]), 32'(e[89:81]));
            e = e << 9;
        end
    endtask

    vec_t        vecs[4];
    logic [639:0] msg_b;

    initial begin
        int   clkn, en_early, fd0, base, bad;
        int   rises[$];
        logic pe;
        logic [8:0] expw;
        logic [7:0] offs[4];

        n_vec = 0;
        n_err = 0;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        if_a.msg = '0;
        if_a.update = 1'b0;
        if_b.update = 1'b0;
        msg_b = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 20; c++)
                msg_b = {msg_b[631:0], (r == 0 && c == 5) ? 8'h00 : 8'h41 + 8'(c)};
        if_b.msg = msg_b;

        vecs[0].msg = "ABCDEFGH";
        vecs[0].exp = {9'h080, 9'h141, 9'h142, 9'h143, 9'h144,
                       9'h0C0, 9'h145, 9'h146, 9'h147, 9'h148};
        vecs[1].msg = {"A", 8'h00, 8'h00, "B", "WXYZ"};
        vecs[1].exp = {9'h080, 9'h141, 9'h120, 9'h120, 9'h142,
                       9'h0C0, 9'h157, 9'h158, 9'h159, 9'h15A};
        vecs[2].msg = 64'h0;
        vecs[2].exp = {9'h080, 9'h120, 9'h120, 9'h120, 9'h120,
                       9'h0C0, 9'h120, 9'h120, 9'h120, 9'h120};
        vecs[3].msg = {"1234", 8'h7E, 8'hFF, 8'h00, 8'h01};
        vecs[3].exp = {9'h080, 9'h131, 9'h132, 9'h133, 9'h134,
                       9'h0C0, 9'h17E, 9'h1FF, 9'h120, 9'h101};

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_rs",   32'(if_a.rs),         32'd0);
        check("rst_rw",   32'(if_a.rw),         32'd0);
        check("rst_en",   32'(if_a.en),         32'd0);
        check("rst_data", 32'(if_a.data),       32'h00);
        check("rst_busy", 32'(if_a.busy),       32'd1);
        check("rst_fd",   32'(if_a.frame_done), 32'd0);
        check("rst_b_busy", 32'(if_b.busy),     32'd1);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;

        // Power-up wait and INIT sequence.
        clkn = 0; en_early = 0; pe = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            clkn++;
            if (clkn <= 20 && if_a.en) en_early++;
            if (if_a.en && !pe) begin
                rises.push_back(clkn);
                if (rises.size() == 1) begin
                    check("first_data", 32'(if_a.data), 32'h38);
                    check("first_rs",   32'(if_a.rs),   32'd0);
                end
            end
            pe = if_a.en;
            if (!if_a.busy) break;
        end
        check("powerup_en_low", 32'(en_early), 32'd0);
        check("init_busy_low",  32'(if_a.busy), 32'd0);
        check("init_slots",     32'(rises.size()), 32'd4);
        if (rises.size() == 4) check("clear_slot_clks", 32'(rises[3] - rises[2]), 32'd32);
        check("init0", 32'(q_a[0]), 32'h038);
        check("init1", 32'(q_a[1]), 32'h00C);
        check("init2", 32'(q_a[2]), 32'h001);
        check("init3", 32'(q_a[3]), 32'h006);

        // Table-driven single frames.
        for (int v = 0; v < 4; v++) begin
            fd0 = fd_a_cnt;
            base = q_a.size();
            if_a.msg = vecs[v].msg;
            pulse_a();
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                if (fd_a_cnt != fd0) break;
            end
            repeat (2) @(negedge clk);
            check($sformatf("v%0d_fd", v),    32'(fd_a_cnt - fd0),    32'd1);
            check($sformatf("v%0d_busy", v),  32'(if_a.busy),         32'd0);
            check($sformatf("v%0d_count", v), 32'(q_a.size() - base), 32'd10);
            check_frame($sformatf("v%0d", v), base, vecs[v].exp);
        end

        // Several requests mid-frame plus a message change: one extra frame only.
        fd0 = fd_a_cnt;
        base = q_a.size();
        if_a.msg = "ABCDEFGH";
        pulse_a();
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (q_a.size() >= base + 3) break;
        end
        check("multi_busy_mid", 32'(if_a.busy), 32'd1);
        if_a.msg = "12345678";
        repeat (3) begin
            pulse_a();
            repeat (7) @(negedge clk);
        end
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (fd_a_cnt >= fd0 + 2) break;
        end
        repeat (300) @(negedge clk);
        check("multi_fd",    32'(fd_a_cnt - fd0),    32'd2);
        check("multi_count", 32'(q_a.size() - base), 32'd20);
        check("multi_busy",  32'(if_a.busy),         32'd0);
        check_frame("multi_old", base, vecs[0].exp);
        check_frame("multi_new", base + 10,
                    {9'h080, 9'h131, 9'h132, 9'h133, 9'h134,
                     9'h0C0, 9'h135, 9'h136, 9'h137, 9'h138});

        // 20x4 auto-refresh instance: two back-to-back frames.
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (fd_b_cnt >= 2) break;
        end
        check("b_frames", 32'(fd_b_cnt >= 2), 32'd1);
        check("b_busy_between", 32'(b_drop), 32'd0);
        check("b_rw", 32'(if_b.rw), 32'd0);
        if (fd_b_cnt >= 2) begin
            check("b_fd0_pos", 32'(fd_b_qs[0]), 32'd88);
            check("b_fd1_pos", 32'(fd_b_qs[1]), 32'd172);
        end
        offs[0] = 8'h00; offs[1] = 8'h40; offs[2] = 8'h14; offs[3] = 8'h54;
        if (q_b.size() >= 172) begin
            for (int f = 0; f < 2; f++) begin
                bad = 0;
                for (int r = 0; r < 4; r++) begin
                    base = 4 + 84 * f + 21 * r;
                    check($sformatf("b_f%0d_addr%0d", f, r), 32'(q_b[base]),
                          32'({1'b0, 8'h80 | offs[r]}));
                    for (int c = 0; c < 20; c++) begin
                        expw = {1'b1, (r == 0 && c == 5) ? 8'h20 : 8'h41 + 8'(c)};
                        if (q_b[base + 1 + c] !== expw) bad++;
                    end
                end
                check($sformatf("b_f%0d_chars_bad", f), 32'(bad), 32'd0);
            end
        end else begin
            check("b_capture_count", 32'(q_b.size()), 32'd172);
        end

        // Asynchronous reset in the middle of a CHAR slot.
        if_a.msg = "ABCDEFGH";
        pulse_a();
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (if_a.en && if_a.rs) break;
        end
        check("midrst_in_char", 32'(if_a.en && if_a.rs), 32'd1);
        #1 rst_a_n = 1'b0;
        #1;
        check("midrst_en",   32'(if_a.en),         32'd0);
        check("midrst_rs",   32'(if_a.rs),         32'd0);
        check("midrst_data", 32'(if_a.data),       32'h00);
        check("midrst_busy", 32'(if_a.busy),       32'd1);
        check("midrst_fd",   32'(if_a.frame_done), 32'd0);
        repeat (2) @(negedge clk);
        rst_a_n = 1'b1;
        en_early = 0;
        repeat (20) begin
            @(negedge clk);
            if (if_a.en) en_early++;
        end
        check("midrst_powerup_en_low", 32'(en_early), 32'd0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (if_a.en) break;
        end
        check("midrst_restart_en",   32'(if_a.en),   32'd1);
        check("midrst_restart_data", 32'(if_a.data), 32'h38);
        check("midrst_restart_rs",   32'(if_a.rs),   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_frame_ctrl.md
Name: lcd_frame_ctrl

Overview:
- Parametrised HD44780-class character-LCD controller in 8-bit mode; successor to the fixed 16x2 display driver.
- Generalises rows and columns, derives the enable timing from an internal tick rather than a divided clock, and adds a power-up wait.
- Snapshots the message at frame start and supports on-demand or auto-refresh with an update/busy handshake.
- Sits between application message registers and the LCD pins.

Parameters:
- CLK_DIV, 12000: clk cycles per tick (1 kHz at 12 MHz); legal range is 2 or more.
- EN_TICKS, 10: ticks per command/character slot; minimum 4.
- POWERUP_TICKS, 20: ticks waited after reset before the first init command.
- COLS, 16: characters per row; range 1..20.
- ROWS, 2: display rows; legal values are 1, 2 or 4.
- AUTO_REFRESH, 0: 1 = start a new frame automatically after each frame; 0 = refresh only on update.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- msg  in  8*COLS*ROWS  characters; row r, column c at msg[8*(COLS*ROWS-r*COLS-c)-1 -: 8]
- update  in  1  single-cycle frame request
- busy  out  1  high from reset until idle, and whenever a frame is in progress
- frame_done  out  1  one-clk pulse when the last character slot of a frame ends
- rs  out  1  LCD register select
- rw  out  1  LCD read/write; tied 0
- en  out  1  LCD enable strobe
- data  out  8  LCD data bus

Behaviour:
- Clock and reset:
  - One clock, clk; reset rst_n is asynchronous, active-low.
  - Reset values: rs=0, rw=0, en=0, data=0x00, busy=1, frame_done=0.
  - Reset also clears the tick counter, the pending flag and all state.
  - Reset asserted mid-frame aborts at once; after release the controller restarts from POWERUP.
- Tick generator:
  - Counter runs 0..CLK_DIV-1.
  - tick is asserted for one clk when the counter equals CLK_DIV-1.
  - All FSM and slot activity advances only on tick.
- Slot timing:
  - Slot tick 0: rs and data load; en=0.
  - Slot ticks 1..EN_TICKS-2: en=1.
  - Slot tick EN_TICKS-1: en=0.
  - Next slot starts after EN_TICKS ticks.
  - rs and data are stable for the whole slot; the falling edge of en always occurs with data valid.
  - The clear-display slot lasts 2*EN_TICKS ticks.
- States:
  - POWERUP: wait POWERUP_TICKS ticks with en=0, then go to INIT.
  - INIT: four slots, rs=0, data 0x38, 0x0C, 0x01, 0x06 in that order, then go to IDLE.
  - IDLE: busy=0. Go to FRAME_START if update or pending is set, or if AUTO_REFRESH=1.
  - FRAME_START: lasts zero slots. Latch msg into an internal snapshot, clear pending, set busy=1, set row=0, go to ADDR.
  - ADDR: one slot, rs=0, data=0x80|offset(row). Row offsets are 0x00, 0x40, COLS and 0x40+COLS. Then go to CHAR with col=0.
  - CHAR: one slot per column, rs=1, data=snapshot byte.
    - A byte of 0x00 is sent as 0x20 (space); no column is ever skipped.
    - After col=COLS-1: if row<ROWS-1, increment row and go to ADDR. Otherwise pulse frame_done and go to IDLE, or to FRAME_START when pending=1 or AUTO_REFRESH=1.
- Handshake:
  - update in IDLE is accepted within one tick.
  - update while busy=1 sets pending, so exactly one extra frame follows regardless of how many pulses arrived.
  - update on the same clk as frame_done also sets pending.
  - Changes to msg during a frame do not affect that frame.
- Widths:
  - row and col counters are sized by $clog2 and never wrap past ROWS-1 / COLS-1.
  - The tick counter wraps at CLK_DIV-1.

Test Plan (CLK_DIV=4, EN_TICKS=4, POWERUP_TICKS=5, COLS=4, ROWS=2 unless stated):
- Reset, then idle: en=0 for the first 20 clks; the first en rising edge has data=0x38, rs=0. The INIT bytes are 0x38, 0x0C, 0x01, 0x06, and the 0x01 slot lasts 32 clks. busy falls after INIT.
- msg="ABCDEFGH", one update pulse: en falling-edge sequence is 0x80, A, B, C, D, 0xC0, E, F, G, H, with rs=0 only on the two addresses. frame_done pulses once; busy then drops.
- msg row 0 = "A", 0x00, 0x00, "B": the bytes transmitted are 0x41, 0x20, 0x20, 0x42.
- Three update pulses during a frame, plus msg changed mid-frame: the current frame shows the old text. Exactly one further frame shows the new text, then idle.
- ROWS=4, COLS=20: the address bytes are 0x80, 0xC0, 0x94, 0xD4. AUTO_REFRESH=1: frames repeat back-to-back, busy stays 1, and frame_done pulses once per frame.
- rst_n low mid-CHAR slot: outputs go to reset values immediately, with no clk needed. After release, the POWERUP wait repeats before the first 0x38.
